// File: rtl/axis_frame_length_adjust.sv
// AXI-Stream frame length adjuster: pads short frames with zero bytes up to LENGTH_MIN and
// truncates long frames at LENGTH_MAX, reporting per-frame length/pad/truncate status.
module axis_frame_length_adjust #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LENGTH_MIN = 64,
  parameter int LENGTH_MAX = 1522
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] input_axis_tkeep,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,

  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic [KEEP_WIDTH-1:0] output_axis_tkeep,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,

  output logic                  status_valid,
  input  logic                  status_ready,
  output logic [15:0]           status_frame_len,
  output logic                  status_frame_pad,
  output logic                  status_frame_truncate,
  output logic                  status_frame_user
);

  localparam logic [16:0] MaxLen    = 17'(LENGTH_MAX);
  localparam logic [16:0] MinLen    = 17'(LENGTH_MIN);
  localparam logic [15:0] KeepBytes = 16'(KEEP_WIDTH);

  typedef enum logic [1:0] {StTransfer, StPad, StTruncate} state_e;

  state_e state_q, state_d;

  logic [15:0] count_q, count_d;
  logic        pad_user_q, pad_user_d;
  logic [15:0] pad_len_q, pad_len_d;

  logic        status_valid_q;
  logic [15:0] status_len_q;
  logic        status_pad_q, status_trunc_q, status_user_q;
  logic        status_load;
  logic [15:0] load_len;
  logic        load_pad, load_trunc, load_user;

  logic                  int_valid;
  logic [DATA_WIDTH-1:0] int_data;
  logic [KEEP_WIDTH-1:0] int_keep;
  logic                  int_last, int_user;

  logic                  out_valid_q, out_last_q, out_user_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [KEEP_WIDTH-1:0] out_keep_q;
  logic                  skid_valid_q, skid_last_q, skid_user_q;
  logic [DATA_WIDTH-1:0] skid_data_q;
  logic [KEEP_WIDTH-1:0] skid_keep_q;
  logic                  out_free;

  logic [15:0] beat_bytes;
  logic [16:0] sum, pad_fill;
  logic [15:0] sum_sat;
  logic        slot_free, in_ok, in_fire;
  logic        cross_max, pad_final;

  function automatic logic [KEEP_WIDTH-1:0] keep_mask(input logic [15:0] n);
    logic [KEEP_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      m[i] = (n > 16'(i));
    end
    return m;
  endfunction

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      beat_bytes = beat_bytes + 16'(input_axis_tkeep[i]);
    end
  end

  assign sum       = {1'b0, count_q} + {1'b0, beat_bytes};
  assign sum_sat   = sum[16] ? 16'hFFFF : sum[15:0];
  assign pad_fill  = {1'b0, count_q} + {1'b0, KeepBytes};
  assign pad_final = (pad_fill >= MinLen);
  // Status slot must be free before accepting any beat that can close a frame.
  assign slot_free = ~status_valid_q | status_ready;
  assign in_ok     = ~rst & (~input_axis_tlast | slot_free);
  assign in_fire   = input_axis_tvalid & input_axis_tready;
  // A beat filling exactly to LENGTH_MAX without tlast has to close the output frame now:
  // with one-cycle latency there is no chance to wait and see whether tlast follows.
  assign cross_max = (sum > MaxLen) | (~input_axis_tlast & (sum == MaxLen));
  assign out_free  = ~out_valid_q | output_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StTransfer;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTransfer: begin
        if (in_fire) begin
          if (cross_max) begin
            if (!input_axis_tlast) state_d = StTruncate;
          end else if (input_axis_tlast && sum < MinLen && !pad_final) begin
            state_d = StPad;
          end
        end
      end
      StPad: begin
        if (!skid_valid_q && pad_final) state_d = StTransfer;
      end
      StTruncate: begin
        if (in_fire && input_axis_tlast) state_d = StTransfer;
      end
      default: state_d = StTransfer;
    endcase
  end

  always_comb begin
    input_axis_tready = 1'b0;
    int_valid   = 1'b0;
    int_data    = input_axis_tdata;
    int_keep    = input_axis_tkeep;
    int_last    = 1'b0;
    int_user    = input_axis_tuser;
    count_d     = count_q;
    pad_user_d  = pad_user_q;
    pad_len_d   = pad_len_q;
    status_load = 1'b0;
    load_len    = sum_sat;
    load_pad    = 1'b0;
    load_trunc  = 1'b0;
    load_user   = input_axis_tuser;
    unique case (state_q)
      StTransfer: begin
        input_axis_tready = in_ok & ~skid_valid_q;
        if (in_fire) begin
          int_valid = 1'b1;
          if (cross_max) begin
            int_keep = input_axis_tkeep & keep_mask(16'(LENGTH_MAX) - count_q);
            int_last = 1'b1;
            int_user = 1'b1;
            if (input_axis_tlast) begin
              status_load = 1'b1;
              load_trunc  = 1'b1;
              load_user   = 1'b1;
              count_d     = '0;
            end else begin
              count_d = sum_sat;
            end
          end else if (input_axis_tlast) begin
            if (sum >= MinLen) begin
              int_last    = 1'b1;
              status_load = 1'b1;
              count_d     = '0;
            end else begin
              for (int i = 0; i < KEEP_WIDTH; i++) begin
                if (!input_axis_tkeep[i]) int_data[8*i +: 8] = '0;
              end
              int_keep = keep_mask(16'(LENGTH_MIN) - count_q);
              if (pad_final) begin
                int_last    = 1'b1;
                status_load = 1'b1;
                load_pad    = 1'b1;
                count_d     = '0;
              end else begin
                int_user   = 1'b0;
                count_d    = pad_fill[15:0];
                pad_user_d = input_axis_tuser;
                pad_len_d  = sum_sat;
              end
            end
          end else begin
            count_d = sum_sat;
          end
        end
      end
      StPad: begin
        int_data = '0;
        int_user = 1'b0;
        if (!skid_valid_q) begin
          int_valid = 1'b1;
          if (pad_final) begin
            int_keep    = keep_mask(16'(LENGTH_MIN) - count_q);
            int_last    = 1'b1;
            int_user    = pad_user_q;
            status_load = 1'b1;
            load_len    = pad_len_q;
            load_pad    = 1'b1;
            load_user   = pad_user_q;
            count_d     = '0;
          end else begin
            int_keep = '1;
            count_d  = pad_fill[15:0];
          end
        end
      end
      StTruncate: begin
        input_axis_tready = in_ok;
        if (in_fire) begin
          if (input_axis_tlast) begin
            status_load = 1'b1;
            load_trunc  = (sum > MaxLen);
            load_user   = 1'b1;
            count_d     = '0;
          end else begin
            count_d = sum_sat;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      pad_user_q <= 1'b0;
      pad_len_q  <= '0;
    end else begin
      count_q    <= count_d;
      pad_user_q <= pad_user_d;
      pad_len_q  <= pad_len_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_valid_q <= 1'b0;
      status_len_q   <= '0;
      status_pad_q   <= 1'b0;
      status_trunc_q <= 1'b0;
      status_user_q  <= 1'b0;
    end else if (status_load) begin
      status_valid_q <= 1'b1;
      status_len_q   <= load_len;
      status_pad_q   <= load_pad;
      status_trunc_q <= load_trunc;
      status_user_q  <= load_user;
    end else if (status_ready) begin
      status_valid_q <= 1'b0;
    end
  end

  // Output register plus one-entry skid buffer; the skid drains before new beats are taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      out_user_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_keep_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_user_q  <= 1'b0;
    end else if (skid_valid_q) begin
      if (out_free) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= skid_data_q;
        out_keep_q   <= skid_keep_q;
        out_last_q   <= skid_last_q;
        out_user_q   <= skid_user_q;
        skid_valid_q <= 1'b0;
      end
    end else if (int_valid) begin
      if (out_free) begin
        out_valid_q <= 1'b1;
        out_data_q  <= int_data;
        out_keep_q  <= int_keep;
        out_last_q  <= int_last;
        out_user_q  <= int_user;
      end else begin
        skid_valid_q <= 1'b1;
        skid_data_q  <= int_data;
        skid_keep_q  <= int_keep;
        skid_last_q  <= int_last;
        skid_user_q  <= int_user;
      end
    end else if (output_axis_tready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign output_axis_tvalid    = out_valid_q;
  assign output_axis_tdata     = out_data_q;
  assign output_axis_tkeep     = out_keep_q;
  assign output_axis_tlast     = out_last_q;
  assign output_axis_tuser     = out_user_q;

  assign status_valid          = status_valid_q;
  assign status_frame_len      = status_len_q;
  assign status_frame_pad      = status_pad_q;
  assign status_frame_truncate = status_trunc_q;
  assign status_frame_user     = status_user_q;

endmodule

// File: tb/tb_axis_frame_length_adjust.sv
// Directed bench for axis_frame_length_adjust with LENGTH_MIN=16, LENGTH_MAX=32, 64-bit bus.
module tb_axis_frame_length_adjust;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_tdata = '0;
  logic [7:0]  in_tkeep = '0;
  logic        in_tvalid = 1'b0;
  logic        in_tready;
  logic        in_tlast = 1'b0;
  logic        in_tuser = 1'b0;
  logic [63:0] out_tdata;
  logic [7:0]  out_tkeep;
  logic        out_tvalid;
  logic        out_tready = 1'b1;
  logic        out_tlast;
  logic        out_tuser;
  logic        status_valid;
  logic        status_ready = 1'b1;
  logic [15:0] status_frame_len;
  logic        status_frame_pad;
  logic        status_frame_truncate;
  logic        status_frame_user;

  int   n_vec = 0;
  int   n_bad = 0;
  logic rand_rdy = 1'b0;
  logic b_done = 1'b0;
  logic [73:0] got_q[$];
  logic [73:0] exp_q[$];
  logic [18:0] gst_q[$];
  logic [18:0] est_q[$];

  always #5 clk = ~clk;

  axis_frame_length_adjust #(
    .DATA_WIDTH(64),
    .KEEP_WIDTH(8),
    .LENGTH_MIN(16),
    .LENGTH_MAX(32)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .input_axis_tdata     (in_tdata),
    .input_axis_tkeep     (in_tkeep),
    .input_axis_tvalid    (in_tvalid),
    .input_axis_tready    (in_tready),
    .input_axis_tlast     (in_tlast),
    .input_axis_tuser     (in_tuser),
    .output_axis_tdata    (out_tdata),
    .output_axis_tkeep    (out_tkeep),
    .output_axis_tvalid   (out_tvalid),
    .output_axis_tready   (out_tready),
    .output_axis_tlast    (out_tlast),
    .output_axis_tuser    (out_tuser),
    .status_valid         (status_valid),
    .status_ready         (status_ready),
    .status_frame_len     (status_frame_len),
    .status_frame_pad     (status_frame_pad),
    .status_frame_truncate(status_frame_truncate),
    .status_frame_user    (status_frame_user)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] kexp(input logic [7:0] k);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic logic [7:0] keep_of(input int n);
    logic [7:0] k;
    for (int i = 0; i < 8; i++) k[i] = (i < n);
    return k;
  endfunction

  function automatic logic [63:0] pat(input logic [7:0] base, input int start, input int n,
                                      input logic [7:0] fill);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = (i < n) ? 8'(base + 8'(start + i)) : fill;
    return d;
  endfunction

  function automatic logic [73:0] eb(input logic [63:0] d, input logic [7:0] k, input logic l,
                                     input logic u);
    return {d & kexp(k), k, l, u};
  endfunction

  function automatic logic [18:0] es(input int len, input logic p, input logic t, input logic u);
    return {16'(len), p, t, u};
  endfunction

  // Handshakes are decided at the next posedge from values stable since posedge+1.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_tvalid && out_tready)
        got_q.push_back({out_tdata & kexp(out_tkeep), out_tkeep, out_tlast, out_tuser});
      if (status_valid && status_ready)
        gst_q.push_back({status_frame_len, status_frame_pad, status_frame_truncate,
                         status_frame_user});
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input logic u, output logic ok);
    ok = 1'b0;
    in_tdata  = d;
    in_tkeep  = k;
    in_tlast  = l;
    in_tuser  = u;
    in_tvalid = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = in_tready;
      @(posedge clk);
      #1;
    end
    in_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input int len, input logic user);
    int   nb;
    int   n;
    logic ok;
    nb = (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      n = (len - 8 * b > 8) ? 8 : len - 8 * b;
      send_beat(pat(base, 8 * b, n, 8'hEE), keep_of(n), b == nb - 1, (b == nb - 1) && user, ok);
      if (!ok) check("in_accept", ok, 1'b1);
    end
  endtask

  task automatic collect(input string tag);
    for (int i = 0; i < 500 && (got_q.size() < exp_q.size() || gst_q.size() < est_q.size());
         i++) @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_nbeats"}, got_q.size(), exp_q.size());
    check({tag, "_nstat"}, gst_q.size(), est_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    for (int i = 0; i < est_q.size(); i++)
      if (i < gst_q.size()) check($sformatf("%s_status%0d", tag, i), gst_q[i], est_q[i]);
    got_q.delete();
    exp_q.delete();
    gst_q.delete();
    est_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", out_tvalid, 1'b0);
    check("rst_tdata", out_tdata, 64'h0);
    check("rst_tkeep", out_tkeep, 8'h0);
    check("rst_tlast_tuser", {out_tlast, out_tuser}, 2'b00);
    check("rst_in_tready", in_tready, 1'b0);
    check("rst_status_valid", status_valid, 1'b0);
    check("rst_status_fields",
          {status_frame_len, status_frame_pad, status_frame_truncate, status_frame_user}, 19'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 24 bytes: passes through untouched
    for (int b = 0; b < 3; b++) exp_q.push_back(eb(pat(8'h00, 8 * b, 8, 8'h00), 8'hFF, b == 2, 1'b0));
    est_q.push_back(es(24, 1'b0, 1'b0, 1'b0));
    send_frame(8'h00, 24, 1'b0);
    collect("f24");

    // 5 bytes: zero-filled to 16
    exp_q.push_back(eb(pat(8'h20, 0, 5, 8'h00), 8'hFF, 1'b0, 1'b0));
    exp_q.push_back(eb(64'h0, 8'hFF, 1'b1, 1'b1));
    est_q.push_back(es(5, 1'b1, 1'b0, 1'b1));
    send_frame(8'h20, 5, 1'b1);
    collect("f5");

    // 40 bytes: cut at 32, fifth beat dropped
    for (int b = 0; b < 4; b++)
      exp_q.push_back(eb(pat(8'h30, 8 * b, 8, 8'h00), 8'hFF, b == 3, b == 3));
    est_q.push_back(es(40, 1'b0, 1'b1, 1'b1));
    send_frame(8'h30, 40, 1'b0);
    collect("f40");

    // 33 bytes: one byte over
    for (int b = 0; b < 4; b++)
      exp_q.push_back(eb(pat(8'h60, 8 * b, 8, 8'h00), 8'hFF, b == 3, b == 3));
    est_q.push_back(es(33, 1'b0, 1'b1, 1'b1));
    send_frame(8'h60, 33, 1'b0);
    collect("f33");

    // exactly LENGTH_MIN: not padded
    for (int b = 0; b < 2; b++) exp_q.push_back(eb(pat(8'h90, 8 * b, 8, 8'h00), 8'hFF, b == 1, b == 1));
    est_q.push_back(es(16, 1'b0, 1'b0, 1'b1));
    send_frame(8'h90, 16, 1'b1);
    collect("f16");

    // exactly LENGTH_MAX: not truncated
    for (int b = 0; b < 4; b++) exp_q.push_back(eb(pat(8'hA0, 8 * b, 8, 8'h00), 8'hFF, b == 3, 1'b0));
    est_q.push_back(es(32, 1'b0, 1'b0, 1'b0));
    send_frame(8'hA0, 32, 1'b0);
    collect("f32");

    // 12 bytes: padding completes inside the final beat
    exp_q.push_back(eb(pat(8'hC0, 0, 8, 8'h00), 8'hFF, 1'b0, 1'b0));
    exp_q.push_back(eb(pat(8'hC0, 8, 4, 8'h00), 8'hFF, 1'b1, 1'b0));
    est_q.push_back(es(12, 1'b1, 1'b0, 1'b0));
    send_frame(8'hC0, 12, 1'b0);
    collect("f12");

    // random output backpressure, status held until read
    rand_rdy = 1'b1;
    status_ready = 1'b0;
    for (int b = 0; b < 3; b++) exp_q.push_back(eb(pat(8'h10, 8 * b, 8, 8'h00), 8'hFF, b == 2, 1'b0));
    for (int b = 0; b < 3; b++) exp_q.push_back(eb(pat(8'h50, 8 * b, 8, 8'h00), 8'hFF, b == 2, b == 2));
    est_q.push_back(es(24, 1'b0, 1'b0, 1'b0));
    est_q.push_back(es(24, 1'b0, 1'b0, 1'b1));
    send_frame(8'h10, 24, 1'b0);
    b_done = 1'b0;
    fork
      begin
        send_frame(8'h50, 24, 1'b1);
        b_done = 1'b1;
      end
    join_none
    repeat (40) @(posedge clk);
    #1;
    check("hold_tlast_blocked", b_done, 1'b0);
    check("hold_status_valid", status_valid, 1'b1);
    check("hold_status_len", status_frame_len, 16'd24);
    check("hold_in_tready", {in_tvalid, in_tlast, in_tready}, 3'b110);
    status_ready = 1'b1;
    for (int i = 0; i < 400 && !b_done; i++) @(posedge clk);
    #1;
    check("hold_release", b_done, 1'b1);
    collect("bp");
    rand_rdy = 1'b0;

    // reset while padding a 1-byte frame
    send_frame(8'h70, 1, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("padrst_tvalid", out_tvalid, 1'b0);
    check("padrst_tdata_keep", {out_tdata, out_tkeep, out_tlast, out_tuser}, 74'h0);
    check("padrst_status", {status_valid, status_frame_len, status_frame_pad}, 18'h0);
    check("padrst_in_tready", in_tready, 1'b0);
    rst = 1'b0;
    got_q.delete();
    gst_q.delete();
    @(posedge clk);
    #1;
    for (int b = 0; b < 2; b++) exp_q.push_back(eb(pat(8'hE0, 8 * b, 8, 8'h00), 8'hFF, b == 1, 1'b0));
    est_q.push_back(es(16, 1'b0, 1'b0, 1'b0));
    send_frame(8'hE0, 16, 1'b0);
    collect("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
